// File: rtl/dbus_mem_slave.sv
// Data-bus memory slave: in-order request queue with fixed response latency,
// backed by a word-addressed data RAM and a small CSR window at 0xFFFF_F000.
module dbus_mem_slave #(
    parameter int          MEM_WORDS = 65536,
    parameter int          LATENCY   = 2,
    parameter int          QDEPTH    = 4,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbus_req_valid,
    output logic        dbus_req_ready,
    input  logic [31:0] dbus_req_addr,
    input  logic [31:0] dbus_req_wdata,
    input  logic [3:0]  dbus_req_wstrb,
    output logic        dbus_resp_valid,
    output logic [31:0] dbus_resp_rdata,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int IW = (AW > 6) ? AW : 6;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [3:0]    LAT4 = 4'(LATENCY);
    localparam logic [CW-1:0] QD_C = CW'(QDEPTH);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
            else         res[8*b +: 8] = old_w[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) return {PW{1'b0}};
        else                      return p + PW'(1);
    endfunction

    logic [31:0]   ram_r [MEM_WORDS];
    logic [IW-1:0] q_idx_r   [QDEPTH];
    logic [31:0]   q_wdata_r [QDEPTH];
    logic [3:0]    q_wstrb_r [QDEPTH];
    logic          q_csr_r   [QDEPTH];
    logic [3:0]    q_due_r   [QDEPTH];

    logic [PW-1:0] head_r, tail_r;
    logic [CW-1:0] count_r;
    logic [31:0]   cyc_r;
    logic [15:0]   lfsr_r;
    logic [31:0]   scratch_r;

    logic          stall_s, accept_s, req_csr_s, q_pop_s, byp_s, push_s, fire_s;
    logic [IW-1:0] op_idx_s;
    logic [31:0]   op_wdata_s, rd_s;
    logic [3:0]    op_wstrb_s;
    logic          op_csr_s, op_store_s, csr_wr_s;
    logic [7:0]    op_off_s;
    logic          unused_s;

    assign unused_s       = ^dbus_req_addr[1:0];
    assign stall_s        = (STALL_EN != 0) && (lfsr_r[1:0] == 2'b00);
    assign dbus_req_ready = !stall_s && (count_r < QD_C);
    assign accept_s       = dbus_req_valid && dbus_req_ready;
    assign req_csr_s      = ((dbus_req_addr & 32'hFFFF_FF00) == 32'hFFFF_F000);
    assign q_pop_s        = (count_r != {CW{1'b0}}) && (q_due_r[head_r] == (cyc_r[3:0] + 4'd1));
    // With a 1-cycle latency the response must be registered on the accept edge itself.
    assign byp_s          = (LATENCY == 1) && accept_s;
    assign push_s         = accept_s && !byp_s;
    assign fire_s         = q_pop_s || byp_s;

    // Select the operation retiring this cycle: queue head, or the bypassed request.
    always_comb begin
        op_idx_s   = {IW{1'b0}};
        op_wdata_s = 32'h0000_0000;
        op_wstrb_s = 4'b0000;
        op_csr_s   = 1'b0;
        if (q_pop_s) begin
            op_idx_s   = q_idx_r[head_r];
            op_wdata_s = q_wdata_r[head_r];
            op_wstrb_s = q_wstrb_r[head_r];
            op_csr_s   = q_csr_r[head_r];
        end else begin
            op_idx_s   = dbus_req_addr[IW+1:2];
            op_wdata_s = dbus_req_wdata;
            op_wstrb_s = dbus_req_wstrb;
            op_csr_s   = req_csr_s;
        end
    end

    assign op_off_s   = {op_idx_s[5:0], 2'b00};
    assign op_store_s = (op_wstrb_s != 4'b0000);
    assign csr_wr_s   = fire_s && op_csr_s && op_store_s;

    // Read data for the retiring operation; stores return zero.
    always_comb begin
        rd_s = 32'h0000_0000;
        if (op_store_s) begin
            rd_s = 32'h0000_0000;
        end else if (op_csr_s) begin
            case (op_off_s)
                8'h00:   rd_s = cyc_r;
                8'h04:   rd_s = scratch_r;
                default: rd_s = 32'h0000_0000;
            endcase
        end else begin
            rd_s = ram_r[op_idx_s[AW-1:0]];
        end
    end

    // RAM store at retire time; contents survive reset.
    always_ff @(posedge clk) begin
        if (fire_s && !op_csr_s && op_store_s) begin
            ram_r[op_idx_s[AW-1:0]] <= byte_merge(ram_r[op_idx_s[AW-1:0]], op_wdata_s, op_wstrb_s);
        end
    end

    // Queue payload capture at the tail slot.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_idx_r[tail_r]   <= dbus_req_addr[IW+1:2];
            q_wdata_r[tail_r] <= dbus_req_wdata;
            q_wstrb_r[tail_r] <= dbus_req_wstrb;
            q_csr_r[tail_r]   <= req_csr_s;
            q_due_r[tail_r]   <= cyc_r[3:0] + LAT4;
        end
    end

    // Queue pointers, occupancy, free-running cycle counter and stall LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            cyc_r   <= 32'h0000_0000;
            lfsr_r  <= LFSR_SEED;
        end else begin
            cyc_r  <= cyc_r + 32'd1;
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
            if (push_s)  tail_r <= ptr_inc(tail_r);
            if (q_pop_s) head_r <= ptr_inc(head_r);
            case ({push_s, q_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered response, CSR scratch and tohost side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_resp_valid <= 1'b0;
            dbus_resp_rdata <= 32'h0000_0000;
            tohost_valid    <= 1'b0;
            tohost_data     <= 32'h0000_0000;
            scratch_r       <= 32'h0000_0000;
        end else begin
            dbus_resp_valid <= fire_s;
            dbus_resp_rdata <= fire_s ? rd_s : 32'h0000_0000;
            tohost_valid    <= csr_wr_s && (op_off_s == 8'h08);
            if (csr_wr_s && (op_off_s == 8'h08)) tohost_data <= op_wdata_s;
            if (csr_wr_s && (op_off_s == 8'h04)) scratch_r <= byte_merge(scratch_r, op_wdata_s, op_wstrb_s);
        end
    end

endmodule

// File: tb/tb_dbus_mem_slave.sv
// Directed bench for dbus_mem_slave: three instances cover LATENCY=2,
// LATENCY=8 (queue full / reset drop) and STALL_EN=1 (random ops, scoreboard).
module tb_dbus_mem_slave;

    logic             clk = 1'b0;
    logic [2:0]       rst_n;
    logic [2:0]       req_valid;
    logic [2:0][31:0] req_addr;
    logic [2:0][31:0] req_wdata;
    logic [2:0][3:0]  req_wstrb;
    wire  [2:0]       req_ready;
    wire  [2:0]       resp_valid;
    wire  [2:0][31:0] resp_rdata;
    wire  [2:0]       tohost_valid;
    wire  [2:0][31:0] tohost_data;

    int          n_chk = 0;
    int          n_bad = 0;
    int          ecnt  = 0;
    logic [2:0]  saw_low;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dbus_mem_slave #(
            .MEM_WORDS((g == 0) ? 65536 : 1024),
            .LATENCY  ((g == 1) ? 8 : 2),
            .QDEPTH   (4),
            .STALL_EN ((g == 2) ? 1 : 0),
            .LFSR_SEED(16'hACE1)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[g]),
            .dbus_req_valid (req_valid[g]),
            .dbus_req_ready (req_ready[g]),
            .dbus_req_addr  (req_addr[g]),
            .dbus_req_wdata (req_wdata[g]),
            .dbus_req_wstrb (req_wstrb[g]),
            .dbus_resp_valid(resp_valid[g]),
            .dbus_resp_rdata(resp_rdata[g]),
            .tohost_valid   (tohost_valid[g]),
            .tohost_data    (tohost_data[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_w(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Present a request at the negedge and hold it until accepted; ends on the accept edge.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int acc, output logic rdy0);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_wstrb[k] = s;
        rdy0 = req_ready[k];
        n = 0;
        while (!req_ready[k] && n < 200) begin
            saw_low[k] = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("req_timeout", 32'(n), 32'd0);
        acc = ecnt + 1;
        @(posedge clk);
    endtask

    task automatic idle(input int k);
        #1;
        req_valid[k] = 1'b0;
        req_wstrb[k] = 4'd0;
    endtask

    task automatic wait_resp(input int k, output int sedge, output logic [31:0] rd);
        int n;
        n = 0;
        sedge = -1;
        rd = 32'd0;
        while (n < 100) begin
            @(negedge clk);
            if (resp_valid[k]) begin
                sedge = ecnt + 1;
                rd = resp_rdata[k];
                break;
            end
            n++;
        end
        if (sedge < 0) check_val("resp_timeout", 32'd0, 32'd1);
    endtask

    // One isolated transaction: checks latency (accept edge to sample edge) and read data.
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp, input int lat, input string tag);
        int acc, se;
        logic r0;
        logic [31:0] rd;
        issue(k, a, d, s, acc, r0);
        idle(k);
        wait_resp(k, se, rd);
        check_val({tag, "_lat"}, 32'(se - acc), 32'(lat));
        check_val({tag, "_rd"}, rd, exp);
    endtask

    int          acc3 [6];
    int          redge [6];
    logic [31:0] rdat [6];
    logic        r0_4, r0_tmp;
    int          got3, g3, acc_t, rcnt;
    int          got6, guard6;
    logic [31:0] mdl [16];
    logic [31:0] exp_q [$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at ecnt=%0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 3'b000;
        req_valid = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        saw_low   = 3'b000;
        repeat (3) @(negedge clk);
        check_val("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check_val("rst_resp_rdata", resp_rdata[0], 32'd0);
        check_val("rst_tohost_valid", 32'(tohost_valid[0]), 32'd0);
        check_val("rst_tohost_data", tohost_data[0], 32'd0);
        rst_n = 3'b111;
        @(negedge clk);
        check_val("rst_ready", 32'(req_ready[0]), 32'd1);

        // Basic store/load and byte-lane merge, LATENCY=2.
        txn(0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 2, "t1_sw");
        txn(0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 2, "t1_lw");
        txn(0, 32'h0000_0101, 32'h0000_AB00, 4'b0010, 32'h0, 2, "t2_sb");
        txn(0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_ABEF, 2, "t2_lw");

        // CSR window: scratch RW with byte merge, tohost pulse, read-zero offsets.
        txn(0, 32'hFFFF_F004, 32'h0000_1234, 4'hF, 32'h0, 2, "t4_sw_scr");
        txn(0, 32'hFFFF_F004, 32'h0, 4'h0, 32'h0000_1234, 2, "t4_lw_scr");
        txn(0, 32'hFFFF_F005, 32'h0000_7700, 4'b0010, 32'h0, 2, "t4_sb_scr");
        txn(0, 32'hFFFF_F004, 32'h0, 4'h0, 32'h0000_7734, 2, "t4_lw_scr2");
        txn(0, 32'hFFFF_F008, 32'h0000_0055, 4'hF, 32'h0, 2, "t4_tohost");
        check_val("t4_tohost_valid", 32'(tohost_valid[0]), 32'd1);
        check_val("t4_tohost_data", tohost_data[0], 32'h0000_0055);
        @(negedge clk);
        check_val("t4_tohost_pulse", 32'(tohost_valid[0]), 32'd0);
        txn(0, 32'hFFFF_F008, 32'h0, 4'h0, 32'h0, 2, "t4_lw_tohost");
        txn(0, 32'hFFFF_F010, 32'h0, 4'h0, 32'h0, 2, "t4_lw_other");

        // LATENCY=8 instance: preload, then six back-to-back loads against QDEPTH=4.
        txn(1, 32'h0000_0100, 32'hDEAD_ABEF, 4'hF, 32'h0, 8, "b_init");
        for (int i = 0; i < 6; i++)
            txn(1, 32'(32'h200 + i * 4), 32'(32'h1000 + i), 4'hF, 32'h0, 8, "b_pre");
        got3 = 0;
        g3 = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    issue(1, 32'(32'h200 + i * 4), 32'h0, 4'h0, acc3[i], r0_tmp);
                    if (i == 4) r0_4 = r0_tmp;
                end
                idle(1);
            end
            begin
                while (got3 < 6 && g3 < 80) begin
                    @(negedge clk);
                    g3++;
                    if (resp_valid[1]) begin
                        redge[got3] = ecnt + 1;
                        rdat[got3]  = resp_rdata[1];
                        got3++;
                    end
                end
                if (got3 < 6) check_val("t3_count", 32'(got3), 32'd6);
            end
        join
        check_val("t3_ready_low_full", 32'(r0_4), 32'd0);
        check_val("t3_fifth_accept", 32'(acc3[4] - acc3[0]), 32'd8);
        for (int i = 0; i < got3; i++) begin
            check_val("t3_lat", 32'(redge[i] - acc3[i]), 32'd8);
            check_val("t3_order_rd", rdat[i], 32'(32'h1000 + i));
        end

        // Reset with two loads in flight: no responses, RAM retained.
        issue(1, 32'h0000_0100, 32'h0, 4'h0, acc_t, r0_tmp);
        issue(1, 32'h0000_0104, 32'h0, 4'h0, acc_t, r0_tmp);
        idle(1);
        rst_n[1] = 1'b0;
        rcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid[1]) rcnt++;
            if (i == 3) rst_n[1] = 1'b1;
        end
        check_val("t5_no_resp", 32'(rcnt), 32'd0);
        check_val("t5_ready", 32'(req_ready[1]), 32'd1);
        txn(1, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_ABEF, 8, "t5_lw");

        // STALL_EN instance: preload a 16-word window, then 1000 random ops vs a model.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = 32'(32'hA500_0000 + i * 32'h0001_0101);
            txn(2, 32'(32'h400 + i * 4), mdl[i], 4'hF, 32'h0, 2, "c_pre");
        end
        got6 = 0;
        guard6 = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int op, w, b;
                    logic [31:0] a, d, e;
                    logic [3:0] s;
                    op = int'($urandom_range(0, 5));
                    w  = int'($urandom_range(0, 15));
                    b  = int'($urandom_range(0, 3));
                    d  = $urandom;
                    e  = 32'h0;
                    case (op)
                        3: s = 4'(4'b0001 << b);
                        4: begin b = b & 2; s = 4'(4'b0011 << b); end
                        5: begin b = 0; s = 4'hF; end
                        default: s = 4'h0;
                    endcase
                    a = 32'(32'h400 + w * 4 + b);
                    if (s == 4'h0) e = mdl[w];
                    else mdl[w] = merge_w(mdl[w], d, s);
                    issue(2, a, d, s, acc_t, r0_tmp);
                    exp_q.push_back(e);
                end
                idle(2);
            end
            begin
                while (got6 < 1000 && guard6 < 20000) begin
                    @(negedge clk);
                    guard6++;
                    if (resp_valid[2]) begin
                        if (exp_q.size() == 0) check_val("c_spurious", 32'd1, 32'd0);
                        else check_val("c_rd", resp_rdata[2], exp_q.pop_front());
                        got6++;
                    end
                end
                if (got6 < 1000) check_val("c_count", 32'(got6), 32'd1000);
            end
        join
        check_val("c_saw_ready_low", 32'(saw_low[2]), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
